// File: rtl/mem_write_arb_pkg.sv
// rtl/mem_write_arb_pkg.sv - shared constants for the posted-write arbiter
//
// Purpose: FIFO depth default, FIFO occupancy counter width helper and
// requester index constants used by mem_write_arb and wr_fifo.
// Ports: none (package).

package mem_write_arb_pkg;

  localparam int DEPTH_DEFAULT = 2;

  localparam int REQ0_IDX = 0;
  localparam int REQ1_IDX = 1;
  localparam int NUM_REQ  = 2;

  // Counter must represent 0..DEPTH inclusive, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(DEPTH_DEFAULT);

endpackage

// File: rtl/wr_fifo.sv
// rtl/wr_fifo.sv - posted-write FIFO holding address/data pairs for one requester
//
// Purpose: DEPTH-entry circular buffer of {addr, data}. The caller only
// pushes when count < DEPTH and only pops when count > 0.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push, push_addr/data enqueue one entry
//   pop                  dequeue the head entry
//   head_addr/head_data  current head entry
//   count                registered occupancy
//   count_next           occupancy after this cycle's push/pop

module wr_fifo
  import mem_write_arb_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int ABITS = 11,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ABITS-1:0] push_addr,
  input  logic [DBITS-1:0] push_data,
  input  logic             pop,
  output logic [ABITS-1:0] head_addr,
  output logic [DBITS-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ABITS-1:0] addr_q [DEPTH];
  logic [ABITS-1:0] addr_d [DEPTH];
  logic [DBITS-1:0] data_q [DEPTH];
  logic [DBITS-1:0] data_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/mem_write_arb.sv
// rtl/mem_write_arb.sv - two-requester round-robin posted-write memory arbiter
//
// Purpose: buffers writes from two requesters in per-requester FIFOs and
// drains them round-robin, one registered memory write per cycle.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   REQ0/1, ADDR0/1, DATA0/1  write requests (accepted when REQn & RDYn)
//   RDY0/1                FIFO n not full (from registered count)
//   MWE, MADDR, MDIN      registered memory write port
//   IDLE                  both FIFOs empty and MWE low (registered)

module mem_write_arb
  import mem_write_arb_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int ABITS = 11,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [ABITS-1:0] ADDR0,
  input  logic [ABITS-1:0] ADDR1,
  input  logic [DBITS-1:0] DATA0,
  input  logic [DBITS-1:0] DATA1,
  output logic             RDY0,
  output logic             RDY1,
  output logic             MWE,
  output logic [ABITS-1:0] MADDR,
  output logic [DBITS-1:0] MDIN,
  output logic             IDLE
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [CNT_W-1:0] cnt0, cnt1, cnt0_next, cnt1_next;
  logic [ABITS-1:0] head_addr0, head_addr1;
  logic [DBITS-1:0] head_data0, head_data1;
  logic             push0, push1, pop0, pop1;
  logic             gnt_valid, gnt_idx;

  logic             mwe_q, mwe_d;
  logic [ABITS-1:0] maddr_q, maddr_d;
  logic [DBITS-1:0] mdin_q, mdin_d;
  logic             last_q, last_d;
  logic             idle_q, idle_d;

  // Full is judged on the registered count, so a pop in the same cycle
  // never frees a slot for a push.
  assign RDY0  = (cnt0 < CNT_W'(DEPTH));
  assign RDY1  = (cnt1 < CNT_W'(DEPTH));
  assign push0 = REQ0 & RDY0;
  assign push1 = REQ1 & RDY1;

  wr_fifo #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH)) u_fifo0 (
    .clk        (CLK),
    .rst        (RESET),
    .push       (push0),
    .push_addr  (ADDR0),
    .push_data  (DATA0),
    .pop        (pop0),
    .head_addr  (head_addr0),
    .head_data  (head_data0),
    .count      (cnt0),
    .count_next (cnt0_next)
  );

  wr_fifo #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH)) u_fifo1 (
    .clk        (CLK),
    .rst        (RESET),
    .push       (push1),
    .push_addr  (ADDR1),
    .push_data  (DATA1),
    .pop        (pop1),
    .head_addr  (head_addr1),
    .head_data  (head_data1),
    .count      (cnt1),
    .count_next (cnt1_next)
  );

  always_comb begin
    gnt_valid = (cnt0 != '0) || (cnt1 != '0);
    // Both pending: the one not served last wins. Otherwise whichever is pending.
    if ((cnt0 != '0) && (cnt1 != '0)) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = (cnt1 != '0);
    end
    pop0 = gnt_valid && (gnt_idx == 1'(REQ0_IDX));
    pop1 = gnt_valid && (gnt_idx == 1'(REQ1_IDX));

    mwe_d   = gnt_valid;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    last_d  = last_q;
    if (gnt_valid) begin
      maddr_d = gnt_idx ? head_addr1 : head_addr0;
      mdin_d  = gnt_idx ? head_data1 : head_data0;
      last_d  = gnt_idx;
    end
    idle_d = (cnt0_next == '0) && (cnt1_next == '0) && !mwe_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mdin_q  <= '0;
      last_q  <= 1'(REQ1_IDX);
      idle_q  <= 1'b1;
    end else begin
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      last_q  <= last_d;
      idle_q  <= idle_d;
    end
  end

  assign MWE   = mwe_q;
  assign MADDR = maddr_q;
  assign MDIN  = mdin_q;
  assign IDLE  = idle_q;

endmodule

// File: tb/tb_mem_write_arb.sv
// tb/tb_mem_write_arb.sv - self-checking bench for mem_write_arb

module tb_mem_write_arb;

  localparam int DBITS = 32;
  localparam int ABITS = 11;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [ABITS-1:0] addr0, addr1;
  logic [DBITS-1:0] data0, data1;
  logic             rdy0, rdy1, mwe, idle;
  logic [ABITS-1:0] maddr;
  logic [DBITS-1:0] mdin;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mem_write_arb #(.DBITS(DBITS), .ABITS(ABITS), .DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RESET (rst),
    .REQ0  (req0),
    .REQ1  (req1),
    .ADDR0 (addr0),
    .ADDR1 (addr1),
    .DATA0 (data0),
    .DATA1 (data1),
    .RDY0  (rdy0),
    .RDY1  (rdy1),
    .MWE   (mwe),
    .MADDR (maddr),
    .MDIN  (mdin),
    .IDLE  (idle)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural model: two queues of {addr,data}, a last-served index and
  // the memory image implied by the grant order.
  logic [ABITS+DBITS-1:0] q0[$];
  logic [ABITS+DBITS-1:0] q1[$];
  int               m_last;
  int               m_g;
  bit               m_a0, m_a1;
  logic             exp_mwe;
  logic [ABITS-1:0] exp_maddr;
  logic [DBITS-1:0] exp_mdin;
  logic [DBITS-1:0] model_mem [2048];
  bit               model_wr  [2048];
  logic [DBITS-1:0] dut_mem   [2048];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_last    = 1;
      exp_mwe   = 1'b0;
      exp_maddr = '0;
      exp_mdin  = '0;
    end else begin
      m_a0 = req0 && (q0.size() < DEPTH);
      m_a1 = req1 && (q1.size() < DEPTH);
      m_g  = -1;
      if (q0.size() > 0 && q1.size() > 0) m_g = (m_last == 1) ? 0 : 1;
      else if (q0.size() > 0)              m_g = 0;
      else if (q1.size() > 0)              m_g = 1;
      exp_mwe = (m_g >= 0);
      if (m_g == 0) {exp_maddr, exp_mdin} = q0.pop_front();
      if (m_g == 1) {exp_maddr, exp_mdin} = q1.pop_front();
      if (m_g >= 0) begin
        m_last = m_g;
        model_mem[exp_maddr] = exp_mdin;
        model_wr[exp_maddr]  = 1'b1;
      end
      if (m_a0) q0.push_back({addr0, data0});
      if (m_a1) q1.push_back({addr1, data1});
    end
  end

  always @(negedge clk) begin
    if (mwe === 1'b1) dut_mem[maddr] = mdin;
    if (chk_en) begin
      check("mwe",   mwe,   exp_mwe);
      check("maddr", maddr, exp_maddr);
      check("mdin",  mdin,  exp_mdin);
      check("rdy0",  rdy0,  q0.size() < DEPTH);
      check("rdy1",  rdy1,  q1.size() < DEPTH);
      check("idle",  idle,  (q0.size() == 0) && (q1.size() == 0) && !exp_mwe);
    end
  end

  bit acc0, acc1;

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    bit pre0, pre1;
    pre0 = rdy0;
    pre1 = rdy1;
    @(posedge clk);
    #1;
    acc0 = req0 && pre0;
    acc1 = req1 && pre1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_mwe",  mwe,  1'b0);
    check("rst_rdy0", rdy0, 1'b1);
    check("rst_rdy1", rdy1, 1'b1);
    check("rst_idle", idle, 1'b1);
    check("rst_maddr", maddr, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  int max_low_run, run0, run1, pulses, pct0, pct1;

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    step();
    do_reset();
    chk_en = 1'b1;

    // Single write.
    req0 = 1; addr0 = 11'h010; data0 = 32'hDEADBEEF;
    step();
    req0 = 0;
    step();
    check("single_mwe",   mwe,   1'b1);
    check("single_maddr", maddr, 11'h010);
    check("single_mdin",  mdin,  32'hDEADBEEF);
    check("single_idle_busy", idle, 1'b0);
    step();
    check("single_mwe_off", mwe,  1'b0);
    check("single_idle",    idle, 1'b1);
    check("single_hold",    maddr, 11'h010);

    // Contention right after reset: requester 0 first.
    do_reset();
    req0 = 1; addr0 = 11'h001; data0 = 32'h11;
    req1 = 1; addr1 = 11'h002; data1 = 32'h22;
    step();
    req0 = 0; req1 = 0;
    step();
    check("cont_first_addr", maddr, 11'h001);
    check("cont_first_data", mdin,  32'h11);
    step();
    check("cont_second_mwe",  mwe,   1'b1);
    check("cont_second_addr", maddr, 11'h002);
    check("cont_second_data", mdin,  32'h22);

    // Both held: continuous draining, FIFO1 fills after two queued.
    req0 = 1; req1 = 1;
    addr0 = 11'h100; data0 = 32'h1000;
    addr1 = 11'h200; data1 = 32'h2000;
    max_low_run = 0; run0 = 0; run1 = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 1) begin
        check("full_rdy1_low",  rdy1, 1'b0);
        check("full_rdy0_high", rdy0, 1'b1);
      end
      if (k >= 1) check("drain_continuous", mwe, 1'b1);
      run0 = rdy0 ? 0 : run0 + 1;
      run1 = rdy1 ? 0 : run1 + 1;
      if (run0 > max_low_run) max_low_run = run0;
      if (run1 > max_low_run) max_low_run = run1;
      if (acc0) begin addr0 = addr0 + 1; data0 = data0 + 1; end
      if (acc1) begin addr1 = addr1 + 1; data1 = data1 + 1; end
    end
    check("max_rdy_low_run", max_low_run, 1);
    req0 = 0; req1 = 0;
    repeat (6) step();

    // Same address from both requesters: later grant wins.
    req0 = 1; addr0 = 11'h005; data0 = 32'hA;
    step();
    req0 = 0;
    req1 = 1; addr1 = 11'h005; data1 = 32'hB;
    step();
    req1 = 0;
    repeat (4) step();
    check("same_addr_dut",   dut_mem[5],   32'hB);
    check("same_addr_model", model_mem[5], 32'hB);

    // Reset while two entries are queued; request held during reset is ignored.
    req0 = 1; addr0 = 11'h300; data0 = 32'h300;
    req1 = 1; addr1 = 11'h301; data1 = 32'h301;
    step();
    step();
    check("middrain_busy", mwe, 1'b1);
    do_reset();
    req0 = 0; req1 = 0;
    pulses = 0;
    repeat (6) begin
      step();
      if (mwe) pulses++;
    end
    check("post_reset_pulses", pulses, 0);

    // Randomized traffic with varying request density.
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 600; i++) begin
      pct0 = (i / 100) % 3 == 0 ? 95 : ((i / 100) % 3 == 1 ? 50 : 20);
      pct1 = (i / 100) % 2 == 0 ? 90 : 35;
      if (!req0 || acc0) begin
        req0  = ($urandom_range(0, 99) < pct0);
        addr0 = 11'($urandom_range(0, 15));
        data0 = $urandom;
      end
      if (!req1 || acc1) begin
        req1  = ($urandom_range(0, 99) < pct1);
        addr1 = 11'($urandom_range(0, 15));
        data1 = $urandom;
      end
      if (i == 350) begin
        do_reset();
        req0 = 0; req1 = 0;
      end
      step();
    end
    req0 = 0; req1 = 0;
    repeat (8) step();
    for (int a = 0; a < 16; a++) begin
      if (model_wr[a]) check("mem_image", dut_mem[a], model_mem[a]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
